// File: rtl/leve2_id.sv
// leve2_id: LEVE decode/operand stage with valid/ready handshakes, busy scoreboard and internal register file.
// Optional macro LEVE2_ID_FWD_EN enables EX/WB operand forwarding; undefined means scoreboard-only stalls.
`default_nettype none

module leve2_id #(
   parameter int XLEN    = 32,
   parameter int NUM_REG = 32
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       IVALID,
   output logic                       IREADY,
   input  logic [XLEN-1:0]            IPC,
   input  logic [31:0]                IINSTR,
   input  logic                       IFLUSH,
   output logic                       OVALID,
   input  logic                       OREADY,
   output logic [XLEN-1:0]            OPC,
   output logic [31:0]                OINSTR,
   output logic [XLEN-1:0]            RS1,
   output logic [XLEN-1:0]            RS2,
   input  logic                       EX_WE,
   input  logic [$clog2(NUM_REG)-1:0] EX_RDA,
   input  logic                       EX_RD_RDY,
   input  logic [XLEN-1:0]            EX_RD,
   input  logic                       WB_WE,
   input  logic [$clog2(NUM_REG)-1:0] WB_RDA,
   input  logic [XLEN-1:0]            WB_RD
);

   localparam int IW = $clog2(NUM_REG);

   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

   logic [XLEN-1:0]    regs [NUM_REG];
   logic [NUM_REG-1:0] busy;
   logic [NUM_REG-1:0] busy_nxt;
   logic [IW-1:0]      out_rd;
   logic               out_we;

   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic [IW-1:0] rd_a;
   logic [IW-1:0] rs1_a;
   logic [IW-1:0] rs2_a;
   logic          writes_op;
   logic          writes;
   logic          use1;
   logic          use2;
   logic          hazard;
   logic          accept;

   assign opcode = IINSTR[6:0];
   assign funct3 = IINSTR[14:12];
   assign rd_a   = IINSTR[7 +: IW];
   assign rs1_a  = IINSTR[15 +: IW];
   assign rs2_a  = IINSTR[20 +: IW];

   always_comb begin
      writes_op = 1'b0;
      use1      = 1'b0;
      use2      = 1'b0;
      case (opcode)
         OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL: writes_op = 1'b1;
         OPCODE_JALR, OPCODE_LOAD, OPCODE_OPIMM: begin
            writes_op = 1'b1;
            use1      = 1'b1;
         end
         OPCODE_BRANCH, OPCODE_STORE: begin
            use1 = 1'b1;
            use2 = 1'b1;
         end
         OPCODE_OP: begin
            writes_op = 1'b1;
            use1      = 1'b1;
            use2      = 1'b1;
         end
         OPCODE_SYSTEM: begin
            writes_op = (funct3 != 3'd0);
            use1      = ~funct3[2];
         end
         default: ;
      endcase
   end

   assign writes = writes_op && (rd_a != '0);

   function automatic logic [XLEN-1:0] resolve(input logic [IW-1:0] a);
      if (a == '0)
         return '0;
`ifdef LEVE2_ID_FWD_EN
      if (EX_WE && (EX_RDA == a) && EX_RD_RDY)
         return EX_RD;
      if (WB_WE && (WB_RDA == a))
         return WB_RD;
`endif
      return regs[a];
   endfunction

   // A pending EX write that is not ready yet (load-use) stalls even with forwarding.
   function automatic logic src_stall(input logic used, input logic [IW-1:0] a);
      logic st;
      st = 1'b0;
      if (used && (a != '0)) begin
`ifdef LEVE2_ID_FWD_EN
         if (EX_WE && (EX_RDA == a))
            st = ~EX_RD_RDY;
         else if (busy[a])
            st = ~(WB_WE && (WB_RDA == a));
`else
         st = busy[a];
`endif
      end
      return st;
   endfunction

`ifndef LEVE2_ID_FWD_EN
   logic unused_ex;
   assign unused_ex = ^{EX_WE, EX_RDA, EX_RD_RDY, EX_RD};
`endif

   assign hazard = src_stall(use1, rs1_a) || src_stall(use2, rs2_a) || (writes && busy[rd_a]);
   assign IREADY = !RST && !IFLUSH && (!OVALID || OREADY) && !hazard;
   assign accept = IVALID && IREADY;

   always_comb begin
      busy_nxt = busy;
      if (WB_WE)
         busy_nxt[WB_RDA] = 1'b0;
      if (IFLUSH && OVALID && out_we)
         busy_nxt[out_rd] = 1'b0;
      if (accept && writes)
         busy_nxt[rd_a] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         OVALID <= 1'b0;
      end else if (IFLUSH) begin
         OVALID <= 1'b0;
      end else if (accept) begin
         OVALID <= 1'b1;
         OPC    <= IPC;
         OINSTR <= IINSTR;
         RS1    <= resolve(rs1_a);
         RS2    <= resolve(rs2_a);
         out_rd <= rd_a;
         out_we <= writes;
      end else if (OREADY) begin
         OVALID <= 1'b0;
      end
   end

   // Register file is intentionally unreset; x0 is never written and is masked on read.
   always_ff @(posedge CLK) begin
      if (WB_WE && (WB_RDA != '0))
         regs[WB_RDA] <= WB_RD;
   end

endmodule

`default_nettype wire

// File: tb/tb_leve2_id.sv
// Directed self-checking bench for leve2_id; expectations follow the LEVE2_ID_FWD_EN build setting.
`default_nettype none

module tb_leve2_id;

   localparam logic [31:0] I_ADDI_X1_5   = 32'h0050_0093;
   localparam logic [31:0] I_ADD_X3_1_2  = 32'h0020_81B3;
   localparam logic [31:0] I_LW_X5       = 32'h0000_2283;
   localparam logic [31:0] I_ADD_X6_5_5  = 32'h0052_8333;
   localparam logic [31:0] I_ADDI_X7_7   = 32'h0070_0393;
   localparam logic [31:0] I_ADDI_X4_1   = 32'h0010_0213;
   localparam logic [31:0] I_ADD_X0_1_2  = 32'h0020_8033;
   localparam logic [31:0] I_ADD_X8_0_0  = 32'h0000_0433;

   logic        clk = 1'b0;
   logic        rst;
   logic        ivalid;
   logic        iready;
   logic [31:0] ipc;
   logic [31:0] iinstr;
   logic        iflush;
   logic        ovalid;
   logic        oready;
   logic [31:0] opc;
   logic [31:0] oinstr;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        ex_we;
   logic [4:0]  ex_rda;
   logic        ex_rd_rdy;
   logic [31:0] ex_rd;
   logic        wb_we;
   logic [4:0]  wb_rda;
   logic [31:0] wb_rd;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   leve2_id #(.XLEN(32), .NUM_REG(32)) dut (
      .CLK(clk), .RST(rst), .IVALID(ivalid), .IREADY(iready), .IPC(ipc), .IINSTR(iinstr),
      .IFLUSH(iflush), .OVALID(ovalid), .OREADY(oready), .OPC(opc), .OINSTR(oinstr),
      .RS1(rs1), .RS2(rs2), .EX_WE(ex_we), .EX_RDA(ex_rda), .EX_RD_RDY(ex_rd_rdy),
      .EX_RD(ex_rd), .WB_WE(wb_we), .WB_RDA(wb_rda), .WB_RD(wb_rd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
      ivalid = 1'b1;
      ipc    = pc;
      iinstr = instr;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] v);
      wb_we  = 1'b1;
      wb_rda = a;
      wb_rd  = v;
      step();
      wb_we  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ivalid = 1'b0; ipc = '0; iinstr = '0; iflush = 1'b0; oready = 1'b1;
      ex_we = 1'b0; ex_rda = '0; ex_rd_rdy = 1'b0; ex_rd = '0;
      wb_we = 1'b0; wb_rda = '0; wb_rd = '0;

      // Reset
      step(); step();
      chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
      chk("rst_iready", {31'd0, iready}, 32'd0);
      chk("rst_busy", dut.busy, 32'd0);
      rst = 1'b0;

      // Initial acceptance
      offer(32'h100, I_ADDI_X1_5);
      settle();
      chk("init_iready", {31'd0, iready}, 32'd1);
      step();
      ivalid = 1'b0;
      chk("init_ovalid", {31'd0, ovalid}, 32'd1);
      chk("init_opc", opc, 32'h100);
      chk("init_oinstr", oinstr, I_ADDI_X1_5);
      chk("init_rs1", rs1, 32'd0);
      chk("init_busy1", {31'd0, dut.busy[1]}, 32'd1);
      wb(5'd1, 32'd5);
      chk("init_busy1_clr", {31'd0, dut.busy[1]}, 32'd0);
      chk("init_drain", {31'd0, ovalid}, 32'd0);
      wb(5'd2, 32'h22);

      // EX forwarding
      offer(32'h104, I_ADDI_X1_5);
      step();
      offer(32'h108, I_ADD_X3_1_2);
      ex_we = 1'b1; ex_rda = 5'd1; ex_rd_rdy = 1'b1; ex_rd = 32'h1234;
      settle();
`ifdef LEVE2_ID_FWD_EN
      chk("exfwd_iready", {31'd0, iready}, 32'd1);
      step();
      ivalid = 1'b0; ex_we = 1'b0;
      wb(5'd1, 32'h1234);
`else
      chk("exfwd_stall0", {31'd0, iready}, 32'd0);
      step();
      ex_we = 1'b0;
      wb_we = 1'b1; wb_rda = 5'd1; wb_rd = 32'h1234;
      settle();
      chk("exfwd_stall_wb", {31'd0, iready}, 32'd0);
      step();
      wb_we = 1'b0;
      settle();
      chk("exfwd_wb1_iready", {31'd0, iready}, 32'd1);
      step();
      ivalid = 1'b0;
`endif
      chk("exfwd_opc", opc, 32'h108);
      chk("exfwd_rs1", rs1, 32'h1234);
      chk("exfwd_rs2", rs2, 32'h22);
      wb(5'd3, 32'h1256);

      // Load-use stall
      offer(32'h10C, I_LW_X5);
      step();
      ivalid = 1'b0;
      step();
      ex_we = 1'b1; ex_rda = 5'd5; ex_rd_rdy = 1'b0;
      offer(32'h110, I_ADD_X6_5_5);
      settle();
      chk("lu_stall", {31'd0, iready}, 32'd0);
      step();
      ex_we = 1'b0;
      wb_we = 1'b1; wb_rda = 5'd5; wb_rd = 32'hCAFE;
      settle();
`ifdef LEVE2_ID_FWD_EN
      chk("lu_wb_accept", {31'd0, iready}, 32'd1);
      step();
      wb_we = 1'b0;
`else
      chk("lu_wb_stall", {31'd0, iready}, 32'd0);
      step();
      wb_we = 1'b0;
      settle();
      chk("lu_wb1_accept", {31'd0, iready}, 32'd1);
      step();
`endif
      ivalid = 1'b0;
      chk("lu_opc", opc, 32'h110);
      chk("lu_rs1", rs1, 32'hCAFE);
      chk("lu_rs2", rs2, 32'hCAFE);
      wb(5'd6, 32'h66);

      // Backpressure
      offer(32'h200, I_ADD_X8_0_0);
      step();
      oready = 1'b0;
      offer(32'h204, I_ADDI_X4_1);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_iready", {31'd0, iready}, 32'd0);
         chk("bp_ovalid", {31'd0, ovalid}, 32'd1);
         chk("bp_opc", opc, 32'h200);
         chk("bp_oinstr", oinstr, I_ADD_X8_0_0);
         chk("bp_rs1", rs1, 32'd0);
         step();
      end
      oready = 1'b1;
      settle();
      chk("bp_release_iready", {31'd0, iready}, 32'd1);
      step();
      chk("bp_next_opc", opc, 32'h204);
      chk("bp_next_ovalid", {31'd0, ovalid}, 32'd1);

      // WAW on x4
      offer(32'h208, I_ADDI_X4_1);
      settle();
      chk("waw_stall", {31'd0, iready}, 32'd0);
      step();
      wb_we = 1'b1; wb_rda = 5'd4; wb_rd = 32'h1;
      settle();
      chk("waw_stall_wb", {31'd0, iready}, 32'd0);
      step();
      wb_we = 1'b0;
      settle();
      chk("waw_release", {31'd0, iready}, 32'd1);
      step();
      ivalid = 1'b0;
      chk("waw_opc", opc, 32'h208);
      wb(5'd4, 32'h1);
      wb(5'd8, 32'h0);

      // Flush
      offer(32'h300, I_ADDI_X7_7);
      step();
      chk("fl_busy7_set", {31'd0, dut.busy[7]}, 32'd1);
      oready = 1'b0;
      iflush = 1'b1;
      offer(32'h304, I_ADD_X8_0_0);
      settle();
      chk("fl_iready", {31'd0, iready}, 32'd0);
      step();
      iflush = 1'b0; ivalid = 1'b0; oready = 1'b1;
      chk("fl_ovalid", {31'd0, ovalid}, 32'd0);
      chk("fl_busy7", {31'd0, dut.busy[7]}, 32'd0);

      // x0 handling
      offer(32'h400, I_ADD_X0_1_2);
      wb_we = 1'b1; wb_rda = 5'd0; wb_rd = 32'hDEAD;
      settle();
      chk("x0_iready", {31'd0, iready}, 32'd1);
      step();
      chk("x0_rs1", rs1, 32'h1234);
      chk("x0_rs2", rs2, 32'h22);
      chk("x0_busy", dut.busy, 32'd0);
      offer(32'h404, I_ADD_X8_0_0);
      settle();
      chk("x0_rd_iready", {31'd0, iready}, 32'd1);
      step();
      ivalid = 1'b0; wb_we = 1'b0;
      chk("x0_read_rs1", rs1, 32'd0);
      chk("x0_read_rs2", rs2, 32'd0);
      step();
      chk("x0_read_after_wb", {31'd0, dut.busy[0]}, 32'd0);
      wb(5'd8, 32'h0);
      chk("final_busy", dut.busy, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
